// File: rtl/s_axis_cc_arbiter.sv
// Packet-level round-robin merge of N completion streams into one registered output.
// A granted source owns the output until its tlast beat is accepted.
//
// state  | meaning
// IDLE   | no packet locked; round-robin pick among requesters, beat taken without a bubble
// LOCKED | mid-packet; only last_grant is served until its tlast beat is accepted
module s_axis_cc_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH/32,
    parameter int N          = 2,
    parameter int GW         = 1
) (
    input  logic                       user_clk,
    input  logic                       user_reset_n,
    input  logic [N*DATA_WIDTH-1:0]    s_axis_cc_tdata_i,
    input  logic [N*KEEP_WIDTH-1:0]    s_axis_cc_tkeep_i,
    input  logic [N*4-1:0]             s_axis_cc_tuser_i,
    input  logic [N-1:0]               s_axis_cc_tlast_i,
    input  logic [N-1:0]               s_axis_cc_tvalid_i,
    output logic [N-1:0]               s_axis_cc_tready_o,
    output logic [DATA_WIDTH-1:0]      s_axis_cc_tdata,
    output logic [KEEP_WIDTH-1:0]      s_axis_cc_tkeep,
    output logic [3:0]                 s_axis_cc_tuser,
    output logic                       s_axis_cc_tlast,
    output logic                       s_axis_cc_tvalid,
    input  logic [3:0]                 s_axis_cc_tready,
    output logic [GW-1:0]              grant_idx,
    output logic                       busy,
    output logic [15:0]                pkt_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_grant_q;
    logic [GW-1:0]         sel;
    logic                  sel_hit;
    logic                  out_free;
    logic                  accept;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [KEEP_WIDTH-1:0] tkeep_q;
    logic [3:0]            tuser_q;
    logic                  tlast_q;
    logic                  tvalid_q;
    logic [15:0]           pkt_cnt_q;
    logic                  unused_tready;

    assign unused_tready = ^s_axis_cc_tready[3:1];
    assign out_free      = !tvalid_q || s_axis_cc_tready[0];

    // Descending scan: the last hit written is the one closest after last_grant.
    always_comb begin
        sel     = last_grant_q;
        sel_hit = 1'b0;
        if (state_q == LOCKED) begin
            sel_hit = 1'b1;
        end else begin
            for (int k = N; k >= 1; k--) begin
                if (s_axis_cc_tvalid_i[(int'(last_grant_q) + k) % N]) begin
                    sel     = GW'((int'(last_grant_q) + k) % N);
                    sel_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_axis_cc_tready_o = '0;
        if (user_reset_n && sel_hit && out_free) begin
            s_axis_cc_tready_o[sel] = 1'b1;
        end
    end

    assign accept   = s_axis_cc_tready_o[sel] && s_axis_cc_tvalid_i[sel];
    assign sel_last = s_axis_cc_tlast_i[sel];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !sel_last) state_d = LOCKED;
            LOCKED:  if (accept && sel_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(N-1);
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tuser_q      <= '0;
            tlast_q      <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept && state_q == IDLE) begin
                last_grant_q <= sel;
            end
            if (accept) begin
                tvalid_q <= 1'b1;
                tdata_q  <= s_axis_cc_tdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                tkeep_q  <= s_axis_cc_tkeep_i[int'(sel)*KEEP_WIDTH +: KEEP_WIDTH];
                tuser_q  <= s_axis_cc_tuser_i[int'(sel)*4 +: 4];
                tlast_q  <= sel_last;
            end else if (s_axis_cc_tready[0]) begin
                tvalid_q <= 1'b0;
            end
            if (accept && sel_last) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign s_axis_cc_tdata  = tdata_q;
    assign s_axis_cc_tkeep  = tkeep_q;
    assign s_axis_cc_tuser  = tuser_q;
    assign s_axis_cc_tlast  = tlast_q;
    assign s_axis_cc_tvalid = tvalid_q;
    assign grant_idx        = last_grant_q;
    assign busy             = (state_q == LOCKED);
    assign pkt_cnt          = pkt_cnt_q;

endmodule
